// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage hazard bundle: decoded operand/destination info in,
// EX forwarding selects and pipeline stall/flush controls out.
interface pipe_hazard_ctrl_if;
    logic [4:0] IDrs;
    logic [4:0] IDrt;
    logic       IDuseRs;
    logic       IDuseRt;
    logic       IDaImm;
    logic       IDbImm;
    logic       IDwreg;
    logic       IDm2reg;
    logic       IDwmem;
    logic [4:0] IDwn;
    logic       EXjumpTaken;
    logic [1:0] IDselectAlua;
    logic [1:0] IDselectAlub;
    logic [1:0] IDisStoreHazards;
    logic       stall;
    logic       bubble;
    logic       flush;

    modport master (
        output IDrs, IDrt, IDuseRs, IDuseRt,
        output IDaImm, IDbImm, IDwreg, IDm2reg,
        output IDwmem, IDwn, EXjumpTaken,
        input  IDselectAlua, IDselectAlub,
        input  IDisStoreHazards,
        input  stall, bubble, flush
    );

    modport slave (
        input  IDrs, IDrt, IDuseRs, IDuseRt,
        input  IDaImm, IDbImm, IDwreg, IDm2reg,
        input  IDwmem, IDwn, EXjumpTaken,
        output IDselectAlua, IDselectAlub,
        output IDisStoreHazards,
        output stall, bubble, flush
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Forwarding and hazard controller for the 5-stage pipeline.
// Tracks EX/MEM destination info and drives forward selects and stalls.
module pipe_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clrn,
    pipe_hazard_ctrl_if.slave hz,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] fwdCount
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [4:0] exWn;
    logic       exWreg;
    logic       exM2reg;
    logic [4:0] memWn;
    logic       memWreg;
    logic       memM2reg;

    logic exHitRs;
    logic exHitRt;
    logic memHitRs;
    logic memHitRt;
    logic loadUse;
    logic anyFwd;
    logic stallCntSat;
    logic fwdCntSat;

    // Register 0 is hardwired, so it never counts as a match
    always_comb begin
        exHitRs  = exWreg && (exWn != 5'd0) && (exWn == hz.IDrs);
        exHitRt  = exWreg && (exWn != 5'd0) && (exWn == hz.IDrt);
        memHitRs = memWreg && (memWn != 5'd0) && (memWn == hz.IDrs);
        memHitRt = memWreg && (memWn != 5'd0) && (memWn == hz.IDrt);
    end

    always_comb begin
        hz.IDselectAlua = 2'd0;
        if (hz.IDaImm)
            hz.IDselectAlua = 2'd1;
        else if (exHitRs && !exM2reg)
            hz.IDselectAlua = 2'd2;
        else if (memHitRs)
            hz.IDselectAlua = 2'd3;
    end

    always_comb begin
        hz.IDselectAlub = 2'd0;
        if (hz.IDbImm)
            hz.IDselectAlub = 2'd1;
        else if (exHitRt && !exM2reg)
            hz.IDselectAlub = 2'd2;
        else if (memHitRt)
            hz.IDselectAlub = 2'd3;
    end

    always_comb begin
        hz.IDisStoreHazards = 2'd0;
        if (hz.IDwmem) begin
            if (exHitRt && !exM2reg)
                hz.IDisStoreHazards = 2'd1;
            else if (memHitRt)
                hz.IDisStoreHazards = 2'd2;
        end
    end

    // A load in EX has no data yet; the consumer waits one cycle
    always_comb begin
        loadUse = exWreg && exM2reg && (exWn != 5'd0) &&
                  ((hz.IDuseRs && (exWn == hz.IDrs)) ||
                   (hz.IDuseRt && (exWn == hz.IDrt)));
    end

    always_comb begin
        hz.stall  = 1'b0;
        hz.bubble = 1'b0;
        hz.flush  = 1'b0;
        if (hz.EXjumpTaken) begin
            hz.flush  = 1'b1;
            hz.bubble = 1'b1;
        end else begin
            hz.stall  = loadUse;
            hz.bubble = loadUse;
        end
    end

    always_comb begin
        anyFwd = !hz.bubble &&
                 (hz.IDselectAlua[1] ||
                  hz.IDselectAlub[1] ||
                  (hz.IDisStoreHazards != 2'd0));
        stallCntSat = &stallCount;
        fwdCntSat   = &fwdCount;
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            exWn     <= 5'd0;
            exWreg   <= 1'b0;
            exM2reg  <= 1'b0;
            memWn    <= 5'd0;
            memWreg  <= 1'b0;
            memM2reg <= 1'b0;
        end else begin
            memWn    <= exWn;
            memWreg  <= exWreg;
            memM2reg <= exM2reg;
            if (hz.bubble) begin
                exWn    <= 5'd0;
                exWreg  <= 1'b0;
                exM2reg <= 1'b0;
            end else begin
                exWn    <= hz.IDwn;
                exWreg  <= hz.IDwreg;
                exM2reg <= hz.IDm2reg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            stallCount <= '0;
            fwdCount   <= '0;
        end else begin
            if (hz.stall && !stallCntSat)
                stallCount <= stallCount + CNT_ONE;
            if (anyFwd && !fwdCntSat)
                fwdCount <= fwdCount + CNT_ONE;
        end
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Forwarding and hazard controller for the 5-stage pipeline. It sits in ID and drives the EX forwarding mux selects (IDselectAlua, IDselectAlub, IDisStoreHazards), which the ID/EX register carries into EX. It also generates load-use stall, bubble and jump flush controls. It keeps a shadow pipeline of destination-register info for the EX and MEM stages, plus saturating stall and forward event counters.

Parameters:
CNT_W, 32, width of the stall and forward event counters

Ports:
clk  input  1  pipeline clock, rising edge
clrn  input  1  synchronous active-low reset
IDrs  input  5  rs field of the instruction in ID
IDrt  input  5  rt field of the instruction in ID
IDuseRs  input  1  ID instruction reads rs
IDuseRt  input  1  ID instruction reads rt (includes store data)
IDaImm  input  1  ALU operand A takes saOrImme (shifts)
IDbImm  input  1  ALU operand B takes saOrImme
IDwreg  input  1  ID instruction writes the register file
IDm2reg  input  1  ID instruction is a load
IDwmem  input  1  ID instruction is a store
IDwn  input  5  destination register of the ID instruction
EXjumpTaken  input  1  instruction in EX resolved a taken jump or branch
IDselectAlua  output  2  A mux select: 0=qa, 1=saOrImme, 2=MEMaluResult, 3=WBdata
IDselectAlub  output  2  B mux select, same encoding
IDisStoreHazards  output  2  store-data select: 0=qb, 1=MEMaluResult, 2=WBdata
stall  output  1  hold PC and IF/ID register
bubble  output  1  zero wreg/m2reg/wmem/jumpType into ID/EX
flush  output  1  clear IF/ID register
stallCount  output  CNT_W  load-use stall cycles, saturating
fwdCount  output  CNT_W  cycles with any forwarding select active, saturating

Behaviour:
- Shadow state: exWn, exWreg, exM2reg, memWn, memWreg, memM2reg.
- Shadow state update on every clock edge:
  - mem* <= ex*.
  - ex* <= ID values, or all zero when bubble=1.
- Match definitions:
  - hitEX(r) = exWreg & exWn!=0 & exWn==r.
  - hitMEM(r) = memWreg & memWn!=0 & memWn==r.
  - Register 0 is never forwarded.
- IDselectAlua (combinational), first true rule wins:
  - IDaImm -> 1.
  - hitEX(IDrs) & !exM2reg -> 2.
  - hitMEM(IDrs) -> 3.
  - otherwise 0.
  - EX match has priority over MEM match (newest value wins).
- IDselectAlub: same rules using IDbImm and IDrt.
- IDisStoreHazards: only when IDwmem=1.
  - hitEX(IDrt) & !exM2reg -> 1.
  - hitMEM(IDrt) -> 2.
  - otherwise 0.
  - Forced to 0 when IDwmem=0.
- Load-use hazard: loadUse = exWreg & exM2reg & exWn!=0 & ((IDuseRs & exWn==IDrs) | (IDuseRt & exWn==IDrt)). This includes store data sourced from a load in EX.
- Jump handling: if EXjumpTaken=1:
  - flush=1, bubble=1, stall=0 (jump overrides load-use).
- Otherwise:
  - stall=loadUse, bubble=loadUse, flush=0.
- During a stall the ID instruction is re-evaluated next cycle. By then the load has moved to MEM, so the select resolves to 3 (or 2 for store data) with no second stall.
- Selects are still computed while bubble=1. They are don't-care because the ID/EX controls are zeroed.
- Counters, registered:
  - stallCount +1 on cycles with loadUse & !EXjumpTaken.
  - fwdCount +1 on cycles with bubble=0 and any of IDselectAlua/IDselectAlub in {2,3} or IDisStoreHazards in {1,2}.
  - Both hold at all-ones (saturate, no wrap).
- Reset (clrn=0 at clk edge): all shadow registers and counters clear to 0.
  - With cleared shadow state, no EX/MEM hits occur.
  - Selects then depend only on IDaImm/IDbImm.
  - stall=bubble=0; flush follows EXjumpTaken.
  - Reset mid-stall drops the stall on the following cycle.
- Latency: selects and hazard controls are combinational in the same cycle; counters update one cycle later.

Test Plan:
- ALU chain: add $3 in EX, ID add using rs=3,rt=3 -> IDselectAlua=2, IDselectAlub=2; one cycle later with no EX hit -> 3, 3; fwdCount=1 then 2.
- Load-use: lw $5 in EX (exM2reg=1), ID uses rs=5 -> stall=bubble=1, stallCount=1; next cycle IDselectAlua=3, stall=0.
- Store data: sw with rt=7, add $7 in EX, IDbImm=1 -> IDselectAlub=1, IDisStoreHazards=1; next cycle -> 2.
- Register zero / priority: exWn=0 with wreg=1 -> select 0; EX and MEM both write $4, ID rs=4 -> select 2.
- Jump during load-use: EXjumpTaken=1 with a loadUse condition -> flush=1, bubble=1, stall=0, stallCount unchanged.
- Reset and saturation: preload counters near all-ones (CNT_W=4, 15 stall cycles then one more) -> stallCount holds at 15; clrn=0 for one edge -> both counters 0, shadow cleared, selects 0.
